dispatch_sched: RTL and testbench
=================================

DISPATCH_SCHED -- requirements
Module: dispatch_sched

Interface
REQ-001 Parameter: HOLD_CYCLES, default 4, number of clocks Enable stays high per dispatched word (legal 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req_valid  input  1  producer offers a request this cycle.
REQ-005 req_data  input  4  payload to deliver.
REQ-006 req_dest  input  2  destination select (00,01,10,11 → outputs 0..3 of downstream 1-to-4 demux).
REQ-007 req_ready  output  1  queue can accept; high whenever count < 4.
REQ-008 data  output  4  payload to demux data input.
REQ-009 Sel  output  2  destination to demux Sel input.
REQ-010 Enable  output  1  demux enable.
REQ-011 busy  output  1  high when state != IDLE or count != 0.
REQ-012 count  output  3  queue occupancy, 0..4.

Function
REQ-013 Queue: 4-entry FIFO of {dest,data} (6 bits/entry); 2-bit read and write pointers wrap 3→0.
REQ-014 Push occurs on a rising edge when req_valid=1 and req_ready=1; req_valid while full is ignored, with no entry written and no count change.
REQ-015 req_ready depends only on registered count, never on req_valid.
REQ-016 Simultaneous push and pop in one cycle: both pointers advance, count unchanged; legal only when count >= 1, since push data is never bypassed to the pop.
REQ-017 FSM states: IDLE, DRIVE, GAP.
REQ-018 IDLE: if count > 0, pop head at next edge, register Sel=dest and data=payload, set Enable=1, load hold counter with HOLD_CYCLES-1, go DRIVE; else stay.
REQ-019 DRIVE: Enable=1 and data/Sel constant; hold counter decrements each edge; at edge where counter = 0, go GAP.
REQ-020 GAP: exactly one cycle with Enable=0, data=0, Sel=00; then IDLE unconditionally.
REQ-021 Whenever Enable=0, data=0 and Sel=00.
REQ-022 All outputs except req_ready are registered.
REQ-023 Latency: word accepted at edge E0 into empty idle block → Enable high after E1.
REQ-024 Enable is high for exactly HOLD_CYCLES consecutive cycles per word.
REQ-025 Back-to-back words: Enable rising edges HOLD_CYCLES+2 cycles apart.
REQ-026 Words leave in acceptance order; none dropped or duplicated.
REQ-027 Pushes are accepted in all FSM states.

Reset
REQ-028 rst_n=0 immediately forces state=IDLE, pointers=0, count=0, hold counter=0, Enable=0, data=0, Sel=00, busy=0, req_ready=1.
REQ-029 Reset during DRIVE aborts the word in progress and discards all queued entries; nothing is delivered after release until new pushes.
REQ-030 First push is accepted on the first rising edge with rst_n=1.

Verification
REQ-031 Single word, HOLD_CYCLES=4: push data=4'hA dest=2'b10 at E0 → after E1 Enable=1, Sel=10, data=A for 4 cycles; then Enable=0, Sel=00, data=0; busy returns to 0.
REQ-032 Fill: push 5 words on consecutive cycles while idle with no pops (first pop occurs E1) → count sequence 1,1,2,3,4 with req_ready low at count=4; 6th push ignored; outputs delivered in order.
REQ-033 Back-to-back: 3 queued words dest 00,01,11 data 1,2,3 → Enable pulses 4 cycles long, rising edges 6 cycles apart, Sel/data match each word.
REQ-034 Wrap-around: push/pop 10 words continuously → pointers wrap twice, delivered sequence identical to pushed sequence.
REQ-035 Mid-operation reset: assert rst_n=0 in 2nd DRIVE cycle with 2 words queued → Enable, data, Sel, count drop to 0 asynchronously; no output activity after release.
REQ-036 HOLD_CYCLES=1: two queued words → Enable high 1 cycle each, rising edges 3 cycles apart.

Source files
------------

// File: rtl/dispatch_sched_if.sv
// dispatch_sched_if -- request/dispatch bundle for dispatch_sched.
//   Producer side : req_valid, req_data[3:0], req_dest[1:0] -> block; req_ready <- block
//   Demux side    : data[3:0], Sel[1:0], Enable <- block
//   Status        : busy, count[2:0] <- block
//   master = producer/observer view, slave = dispatch_sched view.
interface dispatch_sched_if;
  logic       req_valid;
  logic [3:0] req_data;
  logic [1:0] req_dest;
  logic       req_ready;
  logic [3:0] data;
  logic [1:0] Sel;
  logic       Enable;
  logic       busy;
  logic [2:0] count;

  modport master (
    output req_valid, req_data, req_dest,
    input  req_ready, data, Sel, Enable, busy, count
  );

  modport slave (
    input  req_valid, req_data, req_dest,
    output req_ready, data, Sel, Enable, busy, count
  );
endinterface

// File: rtl/dispatch_sched.sv
// dispatch_sched -- 4-entry request queue feeding a 1-to-4 demux.
// Each queued {dest,data} word is presented on data/Sel with Enable held
// high for HOLD_CYCLES clocks, followed by one idle gap cycle.
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : dispatch_sched_if.slave (request handshake, demux drive, status)
module dispatch_sched #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  dispatch_sched_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_DRIVE = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYCLES - 1);

  logic [1:0] r_state;
  logic [1:0] r_wptr;
  logic [1:0] r_rptr;
  logic [2:0] r_count;
  logic [3:0] r_hold;
  logic       r_en;
  logic [3:0] r_data;
  logic [1:0] r_sel;
  logic       r_busy;
  logic [5:0] r_mem [4];

  logic       w_ready;
  logic       w_push;
  logic       w_pop;
  logic [2:0] w_count_nxt;
  logic [1:0] w_state_nxt;

  assign w_ready = (r_count < 3'd4);
  assign w_push  = bus.req_valid && w_ready;
  // Pop only from a non-empty queue, so push data is never bypassed.
  assign w_pop   = (r_state == S_IDLE) && (r_count != 3'd0);
  assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_pop) w_state_nxt = S_DRIVE;
      S_DRIVE: if (r_hold == 4'd0) w_state_nxt = S_GAP;
      S_GAP:   w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Storage needs no reset: pointers and count define validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= {bus.req_dest, bus.req_data};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
      r_hold  <= '0;
      r_en    <= 1'b0;
      r_data  <= '0;
      r_sel   <= '0;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      // busy is registered, so it is computed from next-state values.
      r_busy  <= (w_state_nxt != S_IDLE) || (w_count_nxt != 3'd0);
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop)  r_rptr <= r_rptr + 2'd1;
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_en   <= 1'b1;
            r_data <= r_mem[r_rptr][3:0];
            r_sel  <= r_mem[r_rptr][5:4];
            r_hold <= HOLD_LOAD;
          end
        end
        S_DRIVE: begin
          if (r_hold == 4'd0) begin
            r_en   <= 1'b0;
            r_data <= '0;
            r_sel  <= '0;
          end else begin
            r_hold <= r_hold - 4'd1;
          end
        end
        default: begin
          r_en   <= 1'b0;
          r_data <= '0;
          r_sel  <= '0;
        end
      endcase
    end
  end

  assign bus.req_ready = w_ready;
  assign bus.data      = r_data;
  assign bus.Sel       = r_sel;
  assign bus.Enable    = r_en;
  assign bus.busy      = r_busy;
  assign bus.count     = r_count;

endmodule

// File: tb/tb_dispatch_sched.sv
module tb_dispatch_sched;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dispatch_sched_if if4 ();
  dispatch_sched_if if1 ();

  dispatch_sched #(.HOLD_CYCLES(4)) u_d4 (.clk(clk), .rst_n(rst_n), .bus(if4));
  dispatch_sched #(.HOLD_CYCLES(1)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(if1));

  int checks = 0;
  int errors = 0;

  // Reference model: queue of accepted words plus the time of the last pop.
  bit         use1;
  int         h;
  int         cyc = 0;
  int         next_pop, last_pop;
  bit         have;
  logic [5:0] cur;
  logic [5:0] mq[$];
  logic [5:0] acc_q[$];
  bit         m_push;
  logic [11:0] e_vec, o_vec;

  // Observed values and derived pulse history.
  logic       o_en, o_busy, o_ready;
  logic [1:0] o_sel;
  logic [3:0] o_data;
  logic [2:0] o_count;
  bit         prev_en;
  int         rise_q[$], fall_q[$];
  logic [5:0] deliv_q[$];

  task automatic model_reset();
    mq.delete(); acc_q.delete();
    rise_q.delete(); fall_q.delete(); deliv_q.delete();
    have = 0; next_pop = 0; last_pop = 0; prev_en = 0;
  endtask

  function automatic bit model_idle();
    return (mq.size() == 0) && (!have || cyc > last_pop + h);
  endfunction

  task automatic drive(input bit v, input logic [3:0] d, input logic [1:0] s);
    if4.req_valid = use1 ? 1'b0 : v;
    if4.req_data  = d;
    if4.req_dest  = s;
    if1.req_valid = use1 ? v : 1'b0;
    if1.req_data  = d;
    if1.req_dest  = s;
  endtask

  task automatic sample();
    o_en    = use1 ? if1.Enable    : if4.Enable;
    o_sel   = use1 ? if1.Sel       : if4.Sel;
    o_data  = use1 ? if1.data      : if4.data;
    o_busy  = use1 ? if1.busy      : if4.busy;
    o_count = use1 ? if1.count     : if4.count;
    o_ready = use1 ? if1.req_ready : if4.req_ready;
    o_vec   = {o_en, o_sel, o_data, o_busy, o_count, o_ready};
  endtask

  task automatic step(input bit v, input logic [3:0] d, input logic [1:0] s);
    bit e_en;
    bit e_busy;
    drive(v, d, s);
    @(posedge clk);
    cyc++;
    m_push = v && (mq.size() < 4);
    if (mq.size() > 0 && cyc >= next_pop) begin
      cur = mq.pop_front();
      last_pop = cyc;
      have = 1;
      next_pop = cyc + h + 2;
    end
    if (m_push) begin
      mq.push_back({s, d});
      acc_q.push_back({s, d});
    end
    e_en   = have && (cyc <= last_pop + h - 1);
    e_busy = (mq.size() != 0) || (have && (cyc <= last_pop + h));
    e_vec  = {e_en, (e_en ? cur[5:4] : 2'b00), (e_en ? cur[3:0] : 4'h0),
              e_busy, 3'(mq.size()), (mq.size() < 4)};
    #1;
    sample();
    if (o_en && !prev_en) begin
      rise_q.push_back(cyc);
      deliv_q.push_back({o_sel, o_data});
    end
    if (!o_en && prev_en) fall_q.push_back(cyc);
    prev_en = o_en;
  endtask

  task automatic select(input bit one, input int hold);
    use1 = one;
    h = hold;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    select(0, 4);
    drive(0, 4'h0, 2'b00);
    repeat (3) @(posedge clk);
    #1;
    if ({if4.Enable, if4.Sel, if4.data, if4.busy, if4.count, if4.req_ready} !== 12'b0_00_0000_0_000_1) begin
      errors++;
      $display("FAIL reset_d4 got=%b exp=%b",
               {if4.Enable, if4.Sel, if4.data, if4.busy, if4.count, if4.req_ready}, 12'b0_00_0000_0_000_1);
    end
    checks++;
    if ({if1.Enable, if1.Sel, if1.data, if1.busy, if1.count, if1.req_ready} !== 12'b0_00_0000_0_000_1) begin
      errors++;
      $display("FAIL reset_d1 got=%b exp=%b",
               {if1.Enable, if1.Sel, if1.data, if1.busy, if1.count, if1.req_ready}, 12'b0_00_0000_0_000_1);
    end
    checks++;
    @(negedge clk);
    rst_n = 1'b1;
    // First edge after release must accept a push.
    step(1, 4'h5, 2'b11);
    if (o_count !== 3'd1) begin
      errors++;
      $display("FAIL first_push count got=%0d exp=1", o_count);
    end
    checks++;
    for (int i = 0; i < 40 && !model_idle(); i++) begin
      step(0, 4'h0, 2'b00);
      if (o_vec !== e_vec) begin errors++; $display("FAIL reset_drain cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec); end
      checks++;
    end
    if (deliv_q.size() != 1 || deliv_q[0] !== 6'b11_0101) begin
      errors++;
      $display("FAIL reset_deliver got_n=%0d exp_n=1", deliv_q.size());
    end
    checks++;
  endtask

  task automatic test_single();
    int push_cyc;
    select(0, 4);
    push_cyc = cyc + 1;
    step(1, 4'hA, 2'b10);
    if (o_vec !== e_vec) begin errors++; $display("FAIL single_push got=%b exp=%b", o_vec, e_vec); end
    checks++;
    for (int i = 0; i < 40 && !model_idle(); i++) begin
      step(0, 4'h0, 2'b00);
      if (o_vec !== e_vec) begin errors++; $display("FAIL single cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec); end
      checks++;
    end
    if (rise_q.size() != 1 || fall_q.size() != 1) begin
      errors++;
      $display("FAIL single_pulses got=%0d/%0d exp=1/1", rise_q.size(), fall_q.size());
    end else begin
      if (rise_q[0] - push_cyc !== 1) begin
        errors++; $display("FAIL single_latency got=%0d exp=1", rise_q[0] - push_cyc);
      end
      checks++;
      if (fall_q[0] - rise_q[0] !== 4) begin
        errors++; $display("FAIL single_width got=%0d exp=4", fall_q[0] - rise_q[0]);
      end
      checks++;
      if (deliv_q[0] !== 6'b10_1010) begin
        errors++; $display("FAIL single_word got=%b exp=%b", deliv_q[0], 6'b10_1010);
      end
      checks++;
    end
    checks++;
    if (o_busy !== 1'b0) begin errors++; $display("FAIL single_busy got=%b exp=0", o_busy); end
    checks++;
  endtask

  task automatic test_fill();
    logic [2:0] exp_cnt [5] = '{3'd1, 3'd1, 3'd2, 3'd3, 3'd4};
    logic [5:0] words [6];
    select(0, 4);
    for (int unsigned i = 0; i < 6; i++) words[i] = 6'($urandom_range(0, 63));
    for (int unsigned i = 0; i < 5; i++) begin
      step(1, words[i][3:0], words[i][5:4]);
      if (o_count !== exp_cnt[i]) begin
        errors++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, o_count, exp_cnt[i]);
      end
      checks++;
    end
    if (o_ready !== 1'b0) begin errors++; $display("FAIL fill_ready_full got=%b exp=0", o_ready); end
    checks++;
    step(1, words[5][3:0], words[5][5:4]);
    if (o_count !== 3'd4) begin errors++; $display("FAIL fill_sixth got=%0d exp=4", o_count); end
    checks++;
    for (int i = 0; i < 80 && !model_idle(); i++) begin
      step(0, 4'h0, 2'b00);
      if (o_vec !== e_vec) begin errors++; $display("FAIL fill_drain cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec); end
      checks++;
    end
    if (deliv_q.size() != 5) begin
      errors++; $display("FAIL fill_n got=%0d exp=5", deliv_q.size());
    end else begin
      for (int unsigned i = 0; i < 5; i++) begin
        if (deliv_q[i] !== words[i]) begin
          errors++; $display("FAIL fill_order[%0d] got=%b exp=%b", i, deliv_q[i], words[i]);
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_back_to_back();
    logic [5:0] words [3] = '{6'b00_0001, 6'b01_0010, 6'b11_0011};
    select(0, 4);
    for (int unsigned i = 0; i < 3; i++) step(1, words[i][3:0], words[i][5:4]);
    for (int i = 0; i < 80 && !model_idle(); i++) begin
      step(0, 4'h0, 2'b00);
      if (o_vec !== e_vec) begin errors++; $display("FAIL b2b cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec); end
      checks++;
    end
    if (rise_q.size() != 3 || fall_q.size() != 3) begin
      errors++; $display("FAIL b2b_pulses got=%0d exp=3", rise_q.size());
    end else begin
      for (int unsigned i = 0; i < 3; i++) begin
        if (fall_q[i] - rise_q[i] !== 4 || deliv_q[i] !== words[i]) begin
          errors++;
          $display("FAIL b2b_word[%0d] width got=%0d exp=4 word got=%b exp=%b",
                   i, fall_q[i] - rise_q[i], deliv_q[i], words[i]);
        end
        checks++;
        if (i > 0) begin
          if (rise_q[i] - rise_q[i-1] !== 6) begin
            errors++; $display("FAIL b2b_spacing[%0d] got=%0d exp=6", i, rise_q[i] - rise_q[i-1]);
          end
          checks++;
        end
      end
    end
    checks++;
  endtask

  task automatic test_wrap();
    logic [5:0] words [10];
    int unsigned k = 0;
    select(0, 4);
    for (int unsigned i = 0; i < 10; i++) words[i] = 6'($urandom_range(0, 63));
    for (int i = 0; i < 300 && (k < 10 || !model_idle()); i++) begin
      if (k < 10) step(1, words[k][3:0], words[k][5:4]);
      else        step(0, 4'h0, 2'b00);
      if (m_push) k++;
      if (o_vec !== e_vec) begin errors++; $display("FAIL wrap cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec); end
      checks++;
    end
    if (deliv_q.size() != 10) begin
      errors++; $display("FAIL wrap_n got=%0d exp=10", deliv_q.size());
    end else begin
      for (int unsigned i = 0; i < 10; i++) begin
        if (deliv_q[i] !== words[i]) begin
          errors++; $display("FAIL wrap_order[%0d] got=%b exp=%b", i, deliv_q[i], words[i]);
        end
        checks++;
      end
    end
    checks++;
  endtask

  task automatic test_mid_reset();
    select(0, 4);
    step(1, 4'h7, 2'b01);
    step(1, 4'h8, 2'b10);
    step(1, 4'h9, 2'b11);
    // Now in the second DRIVE cycle with two words queued.
    if (o_vec !== e_vec || o_count !== 3'd2 || o_en !== 1'b1) begin
      errors++; $display("FAIL midrst_pre got=%b exp=%b", o_vec, e_vec);
    end
    checks++;
    drive(0, 4'h0, 2'b00);
    #1 rst_n = 1'b0;
    #1;
    sample();
    if (o_vec !== 12'b0_00_0000_0_000_1) begin
      errors++; $display("FAIL midrst_async got=%b exp=%b", o_vec, 12'b0_00_0000_0_000_1);
    end
    checks++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned i = 0; i < 15; i++) begin
      step(0, 4'h0, 2'b00);
      if (o_vec !== e_vec) begin errors++; $display("FAIL midrst_after cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec); end
      checks++;
    end
    if (rise_q.size() != 0) begin
      errors++; $display("FAIL midrst_activity got=%0d exp=0", rise_q.size());
    end
    checks++;
  endtask

  task automatic test_hold1();
    select(1, 1);
    step(1, 4'h3, 2'b01);
    step(1, 4'hC, 2'b10);
    for (int i = 0; i < 40 && !model_idle(); i++) begin
      step(0, 4'h0, 2'b00);
      if (o_vec !== e_vec) begin errors++; $display("FAIL hold1 cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec); end
      checks++;
    end
    if (rise_q.size() != 2 || fall_q.size() != 2) begin
      errors++; $display("FAIL hold1_pulses got=%0d exp=2", rise_q.size());
    end else begin
      if (rise_q[1] - rise_q[0] !== 3) begin
        errors++; $display("FAIL hold1_spacing got=%0d exp=3", rise_q[1] - rise_q[0]);
      end
      checks++;
      if (fall_q[0] - rise_q[0] !== 1 || fall_q[1] - rise_q[1] !== 1) begin
        errors++; $display("FAIL hold1_width got=%0d,%0d exp=1", fall_q[0] - rise_q[0], fall_q[1] - rise_q[1]);
      end
      checks++;
      if (deliv_q[0] !== 6'b01_0011 || deliv_q[1] !== 6'b10_1100) begin
        errors++; $display("FAIL hold1_words got=%b,%b exp=010011,101100", deliv_q[0], deliv_q[1]);
      end
      checks++;
    end
    checks++;
  endtask

  task automatic test_random(input bit one, input int hold, input int n);
    select(one, hold);
    for (int i = 0; i < n; i++) begin
      step(($urandom_range(0, 99) < 45), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)));
      if (o_vec !== e_vec) begin errors++; $display("FAIL random_h%0d cyc=%0d got=%b exp=%b", hold, cyc, o_vec, e_vec); end
      checks++;
    end
    for (int i = 0; i < 80 && !model_idle(); i++) begin
      step(0, 4'h0, 2'b00);
      if (o_vec !== e_vec) begin errors++; $display("FAIL random_drain cyc=%0d got=%b exp=%b", cyc, o_vec, e_vec); end
      checks++;
    end
    if (!model_idle()) begin errors++; $display("FAIL random_timeout got=busy exp=idle"); end
    checks++;
    if (deliv_q.size() != acc_q.size()) begin
      errors++; $display("FAIL random_count got=%0d exp=%0d", deliv_q.size(), acc_q.size());
    end else begin
      for (int unsigned i = 0; i < deliv_q.size(); i++) begin
        if (deliv_q[i] !== acc_q[i]) begin
          errors++; $display("FAIL random_order[%0d] got=%b exp=%b", i, deliv_q[i], acc_q[i]);
        end
        checks++;
      end
    end
    checks++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_back_to_back();
    test_wrap();
    test_mid_reset();
    test_hold1();
    test_random(0, 4, 250);
    test_random(1, 1, 200);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
